// File: rtl/mem_coalescer_pkg.sv
// mem_coalescer_pkg: shared widths, state encoding and lane slicing for mem_coalescer.
package mem_coalescer_pkg;
    localparam int LANES  = 32;
    localparam int LINE_W = 11;
    localparam int LANE_W = 16;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Lane 0 occupies the most significant halfword, matching the memory's halfword order
    function automatic int lane_lo(input int i);
        return (LANES - 1 - i) * LANE_W;
    endfunction
endpackage

// File: rtl/mem_coalescer_lane_priority_enc.sv
// lane_priority_enc: lowest-index set bit of a 32-lane pending vector plus any-valid flag.
module lane_priority_enc (
    input  logic [31:0] i_pend,
    output logic [4:0]  o_idx,
    output logic        o_any
);
    always_comb begin
        o_idx = '0;
        for (int i = 31; i >= 0; i--)
            if (i_pend[i]) o_idx = 5'(i);
    end

    assign o_any = |i_pend;
endmodule

// File: rtl/mem_coalescer.sv
// mem_coalescer: coalesces a 32-lane gather/scatter into one memory line access per distinct line.
module mem_coalescer
    import mem_coalescer_pkg::*;
#(
    parameter int LANES  = 32,
    parameter int LINE_W = 11
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [LANES*16-1:0]     req_addr,
    input  logic [LANES*16-1:0]     req_wdata,
    input  logic [LANES-1:0]        req_mask,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [LANES*16-1:0]     resp_data,
    output logic [5:0]              lines_issued,
    output logic [LINE_W-1:0]       mem_raddr,
    input  logic [LANES*16-1:0]     mem_rdata,
    output logic                    mem_wen64,
    output logic [LINE_W-1:0]       mem_waddr64,
    output logic [LANES*16-1:0]     mem_wdata64,
    output logic [LANES-1:0]        mem_wmask
);
    logic [1:0]            r_state;
    logic                  r_write;
    logic [LANES*16-1:0]   r_addr;
    logic [LANES*16-1:0]   r_wdata;
    logic [LANES*16-1:0]   r_resp;
    logic [LANES-1:0]      r_pend;
    logic [5:0]            r_cnt;
    logic [5:0]            r_lines;

    logic [4:0]            w_leader;
    logic                  w_any;
    logic                  w_busy;
    logic [LINE_W-1:0]     w_line;
    logic [LANES-1:0]      w_hit;
    logic [LANES-1:0]      w_wmask;
    logic [LANES*16-1:0]   w_wdata;

    lane_priority_enc u_enc (
        .i_pend (r_pend),
        .o_idx  (w_leader),
        .o_any  (w_any)
    );

    assign w_busy = r_state == S_BUSY && w_any;
    assign w_line = r_addr[lane_lo(int'(w_leader)) + 5 +: LINE_W];

    // Ascending lane order lets the highest hit lane win a shared halfword
    always_comb begin
        w_hit   = '0;
        w_wmask = '0;
        w_wdata = '0;
        for (int i = 0; i < LANES; i++) begin
            w_hit[i] = r_pend[i] && r_addr[lane_lo(i) + 5 +: LINE_W] == w_line;
            if (w_hit[i]) begin
                w_wmask[r_addr[lane_lo(i) +: 5]] = 1'b1;
                w_wdata[lane_lo(int'(r_addr[lane_lo(i) +: 5])) +: LANE_W] = r_wdata[lane_lo(i) +: LANE_W];
            end
        end
    end

    assign req_ready    = r_state == S_IDLE;
    assign resp_valid   = r_state == S_DONE;
    assign resp_data    = r_resp;
    assign lines_issued = r_lines;
    assign mem_raddr    = w_busy && !r_write ? w_line : '0;
    assign mem_wen64    = w_busy && r_write;
    assign mem_waddr64  = mem_wen64 ? w_line : '0;
    assign mem_wmask    = mem_wen64 ? w_wmask : '0;
    assign mem_wdata64  = mem_wen64 ? w_wdata : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_write <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_resp  <= '0;
            r_pend  <= '0;
            r_cnt   <= '0;
            r_lines <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (req_valid) begin
                    r_write <= req_write;
                    r_addr  <= req_addr;
                    r_wdata <= req_wdata;
                    r_pend  <= req_mask;
                    r_resp  <= '0;
                    r_cnt   <= '0;
                    if (req_mask == '0) r_lines <= '0;
                    r_state <= req_mask == '0 ? S_DONE : S_BUSY;
                end
                S_BUSY: begin
                    r_pend <= r_pend & ~w_hit;
                    r_cnt  <= r_cnt + 6'd1;
                    for (int i = 0; i < LANES; i++)
                        if (w_hit[i] && !r_write)
                            r_resp[lane_lo(i) +: LANE_W] <= mem_rdata[lane_lo(int'(r_addr[lane_lo(i) +: 5])) +: LANE_W];
                    if ((r_pend & ~w_hit) == '0) begin
                        r_lines <= r_cnt + 6'd1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: if (resp_ready) r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_coalescer.sv
// tb_mem_coalescer: directed checks of mem_coalescer against a behavioural line memory.
module tb_mem_coalescer;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic         req_write = 1'b0;
    logic [511:0] req_addr = '0;
    logic [511:0] req_wdata = '0;
    logic [31:0]  req_mask = '0;
    logic         resp_valid;
    logic         resp_ready = 1'b0;
    logic [511:0] resp_data;
    logic [5:0]   lines_issued;
    logic [10:0]  mem_raddr;
    logic [511:0] mem_rdata;
    logic         mem_wen64;
    logic [10:0]  mem_waddr64;
    logic [511:0] mem_wdata64;
    logic [31:0]  mem_wmask;

    always #5 clk = ~clk;

    mem_coalescer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_mask     (req_mask),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_data    (resp_data),
        .lines_issued (lines_issued),
        .mem_raddr    (mem_raddr),
        .mem_rdata    (mem_rdata),
        .mem_wen64    (mem_wen64),
        .mem_waddr64  (mem_waddr64),
        .mem_wdata64  (mem_wdata64),
        .mem_wmask    (mem_wmask)
    );

    logic [511:0] mem [2048];
    assign mem_rdata = mem[mem_raddr];
    always @(posedge clk)
        if (mem_wen64)
            for (int w = 0; w < 32; w++)
                if (mem_wmask[w]) mem[mem_waddr64][(31-w)*16 +: 16] <= mem_wdata64[(31-w)*16 +: 16];

    int n_checks = 0;
    int n_errors = 0;
    int lat;
    logic [511:0] addr_v, wdata_v, exp_v;
    logic [31:0]  mask_v;
    logic [10:0]  raddr_q[$];
    logic [10:0]  waddr_q[$];
    logic [31:0]  wmask_q[$];
    logic [511:0] wdata_q[$];

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] init_hw(input logic [15:0] a);
        return a ^ 16'hC3A5;
    endfunction

    function automatic logic [15:0] mem_hw(input logic [15:0] a);
        return mem[a[15:5]][(31-int'(a[4:0]))*16 +: 16];
    endfunction

    task automatic set_lane(input int i, input logic [15:0] a, input logic [15:0] d);
        addr_v[(31-i)*16 +: 16]  = a;
        wdata_v[(31-i)*16 +: 16] = d;
    endtask

    task automatic send(input logic wr);
        @(negedge clk);
        check("ready_before_req", 512'(req_ready), 512'(1));
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr_v;
        req_wdata = wdata_v;
        req_mask  = mask_v;
        @(posedge clk);
        #1 req_valid = 1'b0;
        raddr_q.delete();
        waddr_q.delete();
        wmask_q.delete();
        wdata_q.delete();
    endtask

    task automatic collect(input int maxc);
        lat = 0;
        while (lat < maxc) begin
            @(negedge clk);
            lat++;
            if (resp_valid) break;
            raddr_q.push_back(mem_raddr);
            if (mem_wen64) begin
                waddr_q.push_back(mem_waddr64);
                wmask_q.push_back(mem_wmask);
                wdata_q.push_back(mem_wdata64);
            end
        end
        if (!resp_valid) check("resp_timeout", 512'(resp_valid), 512'(1));
    endtask

    task automatic finish_resp();
        @(negedge clk) resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ctl"}, 512'({req_ready, resp_valid, lines_issued, mem_raddr, mem_wen64, mem_waddr64, mem_wmask}),
              512'({1'b1, 1'b0, 6'd0, 11'd0, 1'b0, 11'd0, 32'd0}));
        check({tag, "_resp_data"}, resp_data, '0);
        check({tag, "_wdata64"}, mem_wdata64, '0);
    endtask

    initial begin
        for (int l = 0; l < 2048; l++)
            for (int w = 0; w < 32; w++)
                mem[l][(31-w)*16 +: 16] = init_hw(16'(l*32 + w));
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // unit-stride load: one line
        mask_v = '1;
        for (int i = 0; i < 32; i++) begin
            set_lane(i, 16'h0100 + 16'(i), 16'h0);
            exp_v[(31-i)*16 +: 16] = init_hw(16'h0100 + 16'(i));
        end
        send(1'b0);
        collect(40);
        check("unit_latency", 512'(lat), 512'(2));
        check("unit_nlines", 512'(raddr_q.size()), 512'(1));
        check("unit_raddr", 512'(raddr_q[0]), 512'(11'h008));
        check("unit_data", resp_data, exp_v);
        check("unit_lines_issued", 512'(lines_issued), 512'(1));
        finish_resp();

        // stride-32 load: 32 lines in ascending order
        for (int i = 0; i < 32; i++) begin
            set_lane(i, 16'(32*i), 16'h0);
            exp_v[(31-i)*16 +: 16] = init_hw(16'(32*i));
        end
        send(1'b0);
        collect(40);
        check("stride_latency", 512'(lat), 512'(33));
        check("stride_nlines", 512'(raddr_q.size()), 512'(32));
        for (int j = 0; j < 32; j++) check("stride_raddr", 512'(raddr_q[j]), 512'(j));
        check("stride_data", resp_data, exp_v);
        check("stride_lines_issued", 512'(lines_issued), 512'(32));
        finish_resp();

        // partial mask, duplicate addresses in lanes 0 and 9
        mask_v = 32'h0000_0201;
        exp_v = '0;
        for (int i = 0; i < 32; i++) set_lane(i, 16'($urandom), 16'h0);
        set_lane(0, 16'h0123, 16'h0);
        set_lane(9, 16'h0123, 16'h0);
        exp_v[(31-0)*16 +: 16] = init_hw(16'h0123);
        exp_v[(31-9)*16 +: 16] = init_hw(16'h0123);
        send(1'b0);
        collect(40);
        check("dup_latency", 512'(lat), 512'(2));
        check("dup_data", resp_data, exp_v);
        finish_resp();

        // partial mask, two lines, leader order
        set_lane(9, 16'h0456, 16'h0);
        exp_v[(31-9)*16 +: 16] = init_hw(16'h0456);
        send(1'b0);
        collect(40);
        check("two_latency", 512'(lat), 512'(3));
        check("two_raddr0", 512'(raddr_q[0]), 512'(11'h009));
        check("two_raddr1", 512'(raddr_q[1]), 512'(11'h022));
        check("two_data", resp_data, exp_v);
        check("two_lines_issued", 512'(lines_issued), 512'(2));
        finish_resp();

        // empty mask store
        mask_v = '0;
        send(1'b1);
        collect(40);
        check("empty_latency", 512'(lat), 512'(1));
        check("empty_writes", 512'(waddr_q.size()), 512'(0));
        check("empty_lines_issued", 512'(lines_issued), 512'(0));
        finish_resp();

        // store conflict: lanes 3 and 7 on halfword 0x0045, lane 7 wins
        mask_v = 32'h0000_0088;
        for (int i = 0; i < 32; i++) set_lane(i, 16'h7FFF, 16'h1234);
        set_lane(3, 16'h0045, 16'hAAAA);
        set_lane(7, 16'h0045, 16'hBBBB);
        exp_v = '0;
        exp_v[(31-5)*16 +: 16] = 16'hBBBB;
        send(1'b1);
        collect(40);
        check("st_latency", 512'(lat), 512'(2));
        check("st_nwrites", 512'(waddr_q.size()), 512'(1));
        check("st_waddr", 512'(waddr_q[0]), 512'(11'h002));
        check("st_wmask", 512'(wmask_q[0]), 512'(32'h0000_0020));
        check("st_wdata", wdata_q[0], exp_v);
        check("st_mem_0045", 512'(mem_hw(16'h0045)), 512'(16'hBBBB));
        check("st_mem_0044", 512'(mem_hw(16'h0044)), 512'(init_hw(16'h0044)));
        check("st_mem_0046", 512'(mem_hw(16'h0046)), 512'(init_hw(16'h0046)));
        check("st_resp_zero", resp_data, '0);
        finish_resp();

        // backpressure: response held for 5 cycles
        mask_v = '1;
        for (int i = 0; i < 32; i++) begin
            set_lane(i, 16'h0200 + 16'(31 - i), 16'h0);
            exp_v[(31-i)*16 +: 16] = init_hw(16'h0200 + 16'(31 - i));
        end
        send(1'b0);
        collect(40);
        check("bp_latency", 512'(lat), 512'(2));
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp_data_stable", resp_data, exp_v);
            check("bp_handshake", 512'({req_ready, resp_valid}), 512'(2'b01));
        end
        finish_resp();
        check("bp_after", 512'({req_ready, resp_valid}), 512'(2'b10));

        // reset during the third line of a 4-line store
        mask_v = 32'h0000_000F;
        for (int i = 0; i < 32; i++) set_lane(i, 16'h0300 + 16'(32*i), 16'(32'h1111 * (i + 1)));
        send(1'b1);
        @(negedge clk);
        check("rst_w0", 512'({mem_wen64, mem_waddr64}), 512'({1'b1, 11'h018}));
        @(negedge clk);
        check("rst_w1", 512'({mem_wen64, mem_waddr64}), 512'({1'b1, 11'h019}));
        @(negedge clk);
        check("rst_w2", 512'({mem_wen64, mem_waddr64}), 512'({1'b1, 11'h01A}));
        rst_n = 1'b0;
        #1 check_reset_outputs("midrst");
        repeat (2) @(negedge clk);
        check("rst_mem_l0", 512'(mem_hw(16'h0300)), 512'(16'h1111));
        check("rst_mem_l1", 512'(mem_hw(16'h0320)), 512'(16'h2222));
        check("rst_mem_l2", 512'(mem_hw(16'h0340)), 512'(init_hw(16'h0340)));
        check("rst_mem_l3", 512'(mem_hw(16'h0360)), 512'(init_hw(16'h0360)));
        rst_n = 1'b1;

        // recovery: read back the first written line
        mask_v = 32'h0000_0001;
        set_lane(0, 16'h0300, 16'h0);
        exp_v = '0;
        exp_v[511 -: 16] = 16'h1111;
        send(1'b0);
        collect(40);
        check("recover_data", resp_data, exp_v);
        finish_resp();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule
